// File: rtl/pixel_state_ctrl.sv
// rtl/pixel_state_ctrl.sv - frame sequencer driving erase, exposure, ADC ramp and row readout of the pixel array
// All drive outputs are decoded from the next state and registered, so they change together with the state.
module pixel_state_ctrl #(
  parameter int PIXEL_BITS    = 8,
  parameter int ROWS          = 2,
  parameter int ERASE_CYCLES  = 4,
  parameter int EXPOSE_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  out_ready,
  output logic                  erase,
  output logic                  expose,
  output logic                  vbn1,
  output logic                  ramp,
  output logic [PIXEL_BITS-1:0] counter,
  output logic [ROWS-1:0]       read_row,
  output logic                  out_valid,
  output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CONV_CYCLES = 2 ** (PIXEL_BITS + 1);
  localparam int MAX_A = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAX_B = (MAX_A > CONV_CYCLES) ? MAX_A : CONV_CYCLES;
  localparam int MAXV  = (MAX_B > ROWS) ? MAX_B : ROWS;
  localparam int CW    = $clog2(MAXV);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  erase_q, erase_d;
  logic                  expose_q, expose_d;
  logic                  vbn1_q, vbn1_d;
  logic                  ramp_q, ramp_d;
  logic [PIXEL_BITS-1:0] counter_q, counter_d;
  logic [ROWS-1:0]       read_row_q, read_row_d;
  logic                  out_valid_q, out_valid_d;
  logic [RW-1:0]         out_row_q, out_row_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  // The phase counter doubles as the row index while in READ.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_ERASE;
      end
      S_ERASE: begin
        if (cnt_q == CW'(ERASE_CYCLES - 1)) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == CW'(EXPOSE_CYCLES - 1)) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
        end
      end
      S_CONVERT: begin
        if (cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        cnt_d = cnt_q;
        if (out_ready) begin
          if (cnt_q == CW'(ROWS - 1)) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    erase_d     = (state_d == S_ERASE);
    expose_d    = (state_d == S_EXPOSE);
    vbn1_d      = (state_d == S_EXPOSE) && cnt_d[0];
    ramp_d      = (state_d == S_CONVERT) && cnt_d[0];
    counter_d   = (state_d == S_CONVERT) ? cnt_d[PIXEL_BITS:1] : '0;
    read_row_d  = (state_d == S_READ) ? (ROWS'(1) << cnt_d) : '0;
    out_valid_d = (state_d == S_READ);
    out_row_d   = (state_d == S_READ) ? cnt_d[RW-1:0] : '0;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      vbn1_q       <= 1'b0;
      ramp_q       <= 1'b0;
      counter_q    <= '0;
      read_row_q   <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      vbn1_q       <= vbn1_d;
      ramp_q       <= ramp_d;
      counter_q    <= counter_d;
      read_row_q   <= read_row_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign vbn1       = vbn1_q;
  assign ramp       = ramp_q;
  assign counter    = counter_q;
  assign read_row   = read_row_q;
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_state_ctrl.sv
// tb/tb_pixel_state_ctrl.sv - randomized and directed bench for pixel_state_ctrl against a timeline model
module tb_pixel_state_ctrl;

  localparam int E = 4;
  localparam int X = 10;
  localparam int C = 512;
  localparam int P = E + X + C;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       erase, expose, vbn1, ramp, out_valid, busy, frame_done;
  logic [7:0] counter;
  logic [1:0] read_row;
  logic [0:0] out_row;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: frame position t (1 = first erase cycle), current row r.
  bit m_active = 0;
  int m_t = 0;
  int m_r = 0;
  bit m_done = 0;

  int   ramp_edges = 0;
  logic ramp_prev = 1'b0;
  int   latched = -1;

  pixel_state_ctrl #(
    .PIXEL_BITS(8), .ROWS(R), .ERASE_CYCLES(E), .EXPOSE_CYCLES(X)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .out_ready(out_ready),
    .erase(erase), .expose(expose), .vbn1(vbn1), .ramp(ramp),
    .counter(counter), .read_row(read_row), .out_valid(out_valid),
    .out_row(out_row), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic rdy, input logic rn);
    m_done = 0;
    if (!rn) begin
      m_active = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1;
        m_t = 1;
        m_r = 0;
      end
    end else if (m_t <= P) begin
      m_t++;
    end else if (rdy) begin
      if (m_r == R - 1) begin
        m_active = 0;
        m_done = 1;
      end else begin
        m_r++;
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic e, x, v, rp, ov, orow;
    logic [7:0] cnt;
    logic [1:0] rr;
    int k;
    e = 0; x = 0; v = 0; rp = 0; ov = 0; orow = 0; cnt = 0; rr = 0;
    if (m_active) begin
      if (m_t <= E) begin
        e = 1;
      end else if (m_t <= E + X) begin
        x = 1;
        v = ((m_t - E - 1) % 2) == 1;
      end else if (m_t <= P) begin
        k = m_t - E - X - 1;
        rp = (k % 2) == 1;
        cnt = 8'(k / 2);
      end else begin
        rr = 2'(1 << m_r);
        ov = 1;
        orow = 1'(m_r);
      end
    end
    return {14'd0, e, x, v, rp, cnt, rr, ov, orow, logic'(m_active), logic'(m_done)};
  endfunction

  task automatic run_cycle(input logic s, input logic rdy, input logic rn);
    start = s;
    out_ready = rdy;
    reset_n = rn;
    @(posedge clk);
    model_step(s, rdy, rn);
    cyc++;
    #1;
    check("outs", {14'd0, erase, expose, vbn1, ramp, counter, read_row, out_valid, out_row, busy, frame_done},
          model_vec());
    if (erase) ramp_edges = 0;
    if (ramp && !ramp_prev) begin
      ramp_edges++;
      check("ramp_cnt", 32'(counter), 32'(ramp_edges - 1));
      if (ramp_edges == 129) latched = int'(counter);
    end
    ramp_prev = ramp;
  endtask

  task automatic run_frame(input int bp_at, input int bp_len, input int restart_at, input int rst_at,
                           output int done_rel);
    done_rel = -1;
    latched = -1;
    run_cycle(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 1200; i++) begin
      run_cycle(i == restart_at, !(i >= bp_at && i < bp_at + bp_len), i != rst_at);
      if (frame_done) begin
        done_rel = i + 1;
        break;
      end
      if (i == rst_at) break;
    end
  endtask

  initial begin
    int d, d1, d2;

    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      check("idle_busy", 32'(busy), 32'd0);
    end

    run_frame(-1, 0, -1, -1, d);
    check("frame_done_cycle", d, 529);
    check("ramp_edges", ramp_edges, 256);
    check("pixel_code_128", latched, 128);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 1'b1);

    run_frame(527, 5, -1, -1, d);
    check("bp_done_cycle", d, 534);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 1'b1);

    run_frame(-1, 0, 100, -1, d);
    check("restart_ignored", d, 529);
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b1, 1'b1);

    run_frame(-1, 0, -1, 300, d);
    check("rst_no_done", d, -1);
    check("rst_busy", 32'(busy), 32'd0);
    run_cycle(1'b0, 1'b1, 1'b1);
    run_frame(-1, 0, -1, -1, d);
    check("after_rst_frame", d, 529);

    d1 = -1;
    d2 = -1;
    for (int i = 0; i < 1200; i++) begin
      run_cycle(1'b1, 1'b1, 1'b1);
      if (frame_done) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          break;
        end
      end
    end
    check("b2b_period", d2 - d1, 529);
    run_cycle(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      run_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1499) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_state_ctrl.md
# pixel_state_ctrl

Frame sequencer that sits directly upstream of the pixel sensor array. It drives every control input the array consumes: erase, exposure bias clock, ADC ramp and shared counter, and one-hot row read enables. Row readout uses a valid/ready handshake with the downstream bus capture stage, which samples the shared DATA bus. One instance serves the whole array.

## Interface
- `PIXEL_BITS`, 8: width of the ADC counter and pixel value.
- `ROWS`, 2: number of pixel rows, equal to the read-enable width.
- `ERASE_CYCLES`, 4: length of the erase phase in clk cycles; must be ≥1.
- `EXPOSE_CYCLES`, 10: length of the exposure phase in clk cycles; must be even and ≥2.
- `clk  in  1`: single clock; all logic is on its rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `start  in  1`: begins a frame; sampled only in IDLE.
- `out_ready  in  1`: downstream stage accepts the current row.
- `erase  out  1`: drives the array ERASE input.
- `expose  out  1`: drives the array EXPOSE input.
- `vbn1  out  1`: exposure integration clock, drives VBN1.
- `ramp  out  1`: ADC step clock, drives RAMP.
- `counter  out  PIXEL_BITS`: shared ADC count, drives COUNTER.
- `read_row  out  ROWS`: one-hot row read enable, drives each row's READ.
- `out_valid  out  1`: the DATA bus holds row `out_row`.
- `out_row  out  $clog2(ROWS)`: index of the row being presented.
- `busy  out  1`: high whenever the state is not IDLE.
- `frame_done  out  1`: one-cycle pulse after the last row is accepted.

## Operation
- All outputs are registered.
- States and transitions:
  - IDLE → ERASE when `start`=1.
  - ERASE → EXPOSE after ERASE_CYCLES cycles.
  - EXPOSE → CONVERT after EXPOSE_CYCLES cycles.
  - CONVERT → READ after 2·2^PIXEL_BITS cycles.
  - READ → IDLE after row ROWS-1 is accepted.
- One internal phase counter is reloaded on every state entry. Its width covers max(ERASE_CYCLES, EXPOSE_CYCLES, 2^(PIXEL_BITS+1)).
- ERASE: `erase`=1 for the whole phase; all other drive outputs are 0.
- EXPOSE:
  - `expose`=1 for the whole phase.
  - `vbn1`=1 on odd phase cycles (1, 3, …) and 0 on even cycles (0, 2, …).
  - This gives EXPOSE_CYCLES/2 rising edges, all with `expose` already high.
- CONVERT:
  - Each count value k = 0..2^PIXEL_BITS-1 is held for exactly two cycles: `ramp`=0 in the first, `ramp`=1 in the second.
  - `counter` therefore changes only while `ramp`=0 and stays stable across and after each ramp rising edge.
  - `counter` returns to 0 when the state leaves CONVERT.
- READ:
  - Row r is presented with `read_row`=1<<r, `out_row`=r and `out_valid`=1.
  - Transfer occurs on an edge where `out_valid` && `out_ready`.
  - On the next cycle, r advances with no gap cycle. While `out_ready`=0, all READ outputs hold.
  - After the last transfer, the next cycle has `read_row`=0, `out_valid`=0, `frame_done`=1 and state IDLE.
- `start` outside IDLE is ignored, with no queuing. `start` in the same cycle as `frame_done` is accepted.
- `busy` = (state ≠ IDLE), registered together with the state.

## Timing
- Reset: when `reset_n`=0 at an edge, state becomes IDLE and every output is 0 the following cycle. This includes `counter`=0 and `read_row`=0. Reset mid-frame aborts immediately; there is no partial readout.
- Start latency: with `start` sampled at edge 0, `erase`=1 from cycle 1 through cycle ERASE_CYCLES.
- Phases are contiguous. There is no dead cycle between ERASE, EXPOSE, CONVERT and READ.
- Defaults with `out_ready` tied high:
  - erase: cycles 1–4.
  - expose: cycles 5–14, with vbn1 high in cycles 6, 8, 10, 12, 14.
  - convert: cycles 15–526.
  - read: row 0 in cycle 527, row 1 in cycle 528.
  - frame_done: cycle 529.
- `read_row` is never high outside READ and is never multi-hot. `erase`, `expose`, `ramp` and `read_row` are mutually exclusive.

## Test plan
- Reset and idle: hold `reset_n`=0 for 3 cycles, then release with `start`=0 → all outputs 0 for 20 cycles, `busy`=0.
- Full frame with defaults and `out_ready`=1: pulse `start` at cycle 0 → `erase` in cycles 1–4, 5 `vbn1` rising edges within 5–14, 256 ramp rising edges with `counter` equal to 0..255 at each edge, `read_row`=01 then 10, `frame_done` in cycle 529. With a behavioural pixel model attached, scene value 128 produces the expected latched code.
- Backpressure: `out_ready`=0 for 5 cycles while row 0 is presented → `read_row`=01 and `out_valid`=1 held for those 5 cycles. The row advances only the cycle after `out_ready` rises. `frame_done` is delayed by exactly 5 cycles.
- Ignored start: pulse `start` again in cycle 100 (during CONVERT) → frame timing is unchanged and a single `frame_done` appears.
- Reset mid-operation: assert `reset_n`=0 in cycle 300 → all outputs 0 in cycle 301. A new `start` after release reproduces the full-frame timing from that start.
- Back-to-back frames: hold `start`=1 continuously → the next frame's `erase` begins the cycle after `frame_done`, and the period is 529 cycles.
